// File: rtl/rd3_in_commutator_pkg.sv
// Shared types and constants for the radix-3 input commutator.
// Used by the commutator RTL and by its testbench.
package rd3_in_commutator_pkg;

  localparam int SIGN_BIT_DEF = 1;
  localparam int INT_BIT_DEF  = 6;
  localparam int FLT_BIT_DEF  = 6;

  function automatic int calc_dw(input int sign_bit, input int int_bit, input int flt_bit);
    return sign_bit + int_bit + flt_bit;
  endfunction

  localparam int DW_DEF = calc_dw(SIGN_BIT_DEF, INT_BIT_DEF, FLT_BIT_DEF);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  typedef enum logic [1:0] {
    SEG0 = 2'd0,
    SEG1 = 2'd1,
    SEG2 = 2'd2
  } seg_t;

  typedef struct packed {
    logic [DW_DEF-1:0] re;
    logic [DW_DEF-1:0] im;
  } cmplx_t;

endpackage

// File: rtl/rd3_in_commutator_if.sv
// Serial sample input and parallel triple output of the radix-3 input commutator.
interface rd3_in_commutator_if #(
  parameter int DW    = 13,
  parameter int IDX_W = 4
);
  logic             din_vld;
  logic             din_sof;
  logic [DW-1:0]    din_re;
  logic [DW-1:0]    din_im;
  logic [DW-1:0]    out1_re;
  logic [DW-1:0]    out1_im;
  logic [DW-1:0]    out2_re;
  logic [DW-1:0]    out2_im;
  logic [DW-1:0]    out3_re;
  logic [DW-1:0]    out3_im;
  logic             do_vld;
  logic [IDX_W-1:0] do_idx;
  logic             do_sof;
  logic             err_sof;

  modport master (
    output din_vld, din_sof, din_re, din_im,
    input  out1_re, out1_im, out2_re, out2_im, out3_re, out3_im,
    input  do_vld, do_idx, do_sof, err_sof
  );

  modport slave (
    input  din_vld, din_sof, din_re, din_im,
    output out1_re, out1_im, out2_re, out2_im, out3_re, out3_im,
    output do_vld, do_idx, do_sof, err_sof
  );
endinterface

// File: rtl/rd3_in_commutator_seg_bank.sv
// One frame-third sample store: single write port, combinational read port.
// Contents are intentionally not reset.
module rd3_seg_bank #(
  parameter int DEPTH = 9,
  parameter int WIDTH = 26,
  parameter int AW    = 4
) (
  input  logic             clk,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic [AW-1:0]    rd_addr,
  output logic [WIDTH-1:0] rd_data
);

  logic [WIDTH-1:0] mem_r [DEPTH];

  // Sample write into the addressed slot.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_r[wr_addr] <= wr_data;
    end
  end

  assign rd_data = mem_r[rd_addr];

endmodule

// File: rtl/rd3_in_commutator.sv
// Radix-3 input commutator: buffers thirds 0 and 1 of a frame and, during
// third 2, presents x[k], x[k+SEG_LEN], x[k+2*SEG_LEN] in parallel.
module rd3_in_commutator
  import rd3_in_commutator_pkg::*;
#(
  parameter int SIGN_BIT = 1,
  parameter int INT_BIT  = 6,
  parameter int FLT_BIT  = 6,
  parameter int SEG_LEN  = 9,
  parameter int IDX_W    = 4
) (
  input  logic clk,
  input  logic n_rst,
  rd3_in_commutator_if.slave bus
);

  localparam int DW = calc_dw(SIGN_BIT, INT_BIT, FLT_BIT);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(SEG_LEN - 1);

  state_t           state_r;
  seg_t             seg_r;
  logic [IDX_W-1:0] idx_r;

  logic             start_s, accept_s, abort_s;
  logic             wr_a_s, wr_b_s, emit_s;
  seg_t             eff_seg_s, next_seg_s;
  logic [IDX_W-1:0] eff_idx_s, next_idx_s;
  logic [2*DW-1:0]  din_s, rd_a_s, rd_b_s;

  logic [DW-1:0]    out1_re_r, out1_im_r, out2_re_r, out2_im_r, out3_re_r, out3_im_r;
  logic             do_vld_r, do_sof_r, err_sof_r;
  logic [IDX_W-1:0] do_idx_r;

  assign din_s = {bus.din_re, bus.din_im};

  // A start-of-frame sample (new or aborting) is handled as position (SEG0, 0).
  always_comb begin
    start_s  = bus.din_vld & bus.din_sof &
               ((state_r == IDLE) | (seg_r != SEG0) | (idx_r != '0));
    accept_s = bus.din_vld & ((state_r == RUN) | bus.din_sof);
    abort_s  = start_s & (state_r == RUN);
    if (start_s) begin
      eff_seg_s = SEG0;
      eff_idx_s = '0;
    end else begin
      eff_seg_s = seg_r;
      eff_idx_s = idx_r;
    end
    wr_a_s = accept_s & (eff_seg_s == SEG0);
    wr_b_s = accept_s & (eff_seg_s == SEG1);
    emit_s = accept_s & (eff_seg_s == SEG2);
    if (eff_idx_s == IDX_LAST) begin
      next_idx_s = '0;
      case (eff_seg_s)
        SEG0:    next_seg_s = SEG1;
        SEG1:    next_seg_s = SEG2;
        default: next_seg_s = SEG0;
      endcase
    end else begin
      next_idx_s = eff_idx_s + IDX_W'(1);
      next_seg_s = eff_seg_s;
    end
  end

  rd3_seg_bank #(.DEPTH(SEG_LEN), .WIDTH(2*DW), .AW(IDX_W)) u_bank_a (
    .clk(clk), .wr_en(wr_a_s), .wr_addr(eff_idx_s), .wr_data(din_s),
    .rd_addr(eff_idx_s), .rd_data(rd_a_s)
  );

  rd3_seg_bank #(.DEPTH(SEG_LEN), .WIDTH(2*DW), .AW(IDX_W)) u_bank_b (
    .clk(clk), .wr_en(wr_b_s), .wr_addr(eff_idx_s), .wr_data(din_s),
    .rd_addr(eff_idx_s), .rd_data(rd_b_s)
  );

  // Frame sequencing and registered triple outputs.
  always_ff @(posedge clk) begin
    if (n_rst) begin
      state_r   <= IDLE;
      seg_r     <= SEG0;
      idx_r     <= '0;
      out1_re_r <= '0;
      out1_im_r <= '0;
      out2_re_r <= '0;
      out2_im_r <= '0;
      out3_re_r <= '0;
      out3_im_r <= '0;
      do_vld_r  <= 1'b0;
      do_idx_r  <= '0;
      do_sof_r  <= 1'b0;
      err_sof_r <= 1'b0;
    end else begin
      err_sof_r <= abort_s;
      do_vld_r  <= emit_s;
      if (accept_s) begin
        state_r <= RUN;
        seg_r   <= next_seg_s;
        idx_r   <= next_idx_s;
      end
      if (emit_s) begin
        out1_re_r <= rd_a_s[2*DW-1:DW];
        out1_im_r <= rd_a_s[DW-1:0];
        out2_re_r <= rd_b_s[2*DW-1:DW];
        out2_im_r <= rd_b_s[DW-1:0];
        out3_re_r <= bus.din_re;
        out3_im_r <= bus.din_im;
        do_idx_r  <= eff_idx_s;
        do_sof_r  <= (eff_idx_s == '0);
      end
    end
  end

  assign bus.out1_re = out1_re_r;
  assign bus.out1_im = out1_im_r;
  assign bus.out2_re = out2_re_r;
  assign bus.out2_im = out2_im_r;
  assign bus.out3_re = out3_re_r;
  assign bus.out3_im = out3_im_r;
  assign bus.do_vld  = do_vld_r;
  assign bus.do_idx  = do_idx_r;
  assign bus.do_sof  = do_sof_r;
  assign bus.err_sof = err_sof_r;

endmodule

// File: tb/tb_rd3_in_commutator.sv
// Directed bench for rd3_in_commutator: SEG_LEN=9 instance plus a SEG_LEN=2 instance.
module tb_rd3_in_commutator;
  import rd3_in_commutator_pkg::*;

  localparam int DW = 13;

  logic clk;
  logic n_rst;
  int   checks;
  int   errors;

  rd3_in_commutator_if #(.DW(DW), .IDX_W(4)) bus1 ();
  rd3_in_commutator_if #(.DW(DW), .IDX_W(1)) bus2 ();

  rd3_in_commutator #(.SEG_LEN(9), .IDX_W(4)) u_dut (.clk(clk), .n_rst(n_rst), .bus(bus1));
  rd3_in_commutator #(.SEG_LEN(2), .IDX_W(1)) u_dut2 (.clk(clk), .n_rst(n_rst), .bus(bus2));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [DW-1:0] w(input int v);
    return v[DW-1:0];
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input logic vld, input logic sof, input int re, input int im);
    @(negedge clk);
    bus1.din_vld = vld;
    bus1.din_sof = sof;
    bus1.din_re  = w(re);
    bus1.din_im  = w(im);
    @(posedge clk);
    #1;
  endtask

  task automatic step2(input logic vld, input logic sof, input cmplx_t s);
    @(negedge clk);
    bus2.din_vld = vld;
    bus2.din_sof = sof;
    bus2.din_re  = s.re;
    bus2.din_im  = s.im;
    @(posedge clk);
    #1;
    bus2.din_vld = 1'b0;
  endtask

  task automatic exp_none(input string tag, input logic err);
    chk({tag, ".vld"}, bus1.do_vld, 32'd0);
    chk({tag, ".err"}, bus1.err_sof, err);
  endtask

  task automatic exp_triple(input string tag, input int a, input int b, input int c, input int k);
    chk({tag, ".vld"}, bus1.do_vld, 32'd1);
    chk({tag, ".o1re"}, bus1.out1_re, w(a));
    chk({tag, ".o1im"}, bus1.out1_im, w(-a));
    chk({tag, ".o2re"}, bus1.out2_re, w(b));
    chk({tag, ".o2im"}, bus1.out2_im, w(-b));
    chk({tag, ".o3re"}, bus1.out3_re, w(c));
    chk({tag, ".o3im"}, bus1.out3_im, w(-c));
    chk({tag, ".idx"}, bus1.do_idx, k);
    chk({tag, ".sof"}, bus1.do_sof, (k == 0) ? 32'd1 : 32'd0);
    chk({tag, ".err"}, bus1.err_sof, 32'd0);
  endtask

  task automatic exp_zero(input string tag);
    chk({tag, ".o1re"}, bus1.out1_re, 32'd0);
    chk({tag, ".o1im"}, bus1.out1_im, 32'd0);
    chk({tag, ".o2re"}, bus1.out2_re, 32'd0);
    chk({tag, ".o2im"}, bus1.out2_im, 32'd0);
    chk({tag, ".o3re"}, bus1.out3_re, 32'd0);
    chk({tag, ".o3im"}, bus1.out3_im, 32'd0);
    chk({tag, ".vld"}, bus1.do_vld, 32'd0);
    chk({tag, ".idx"}, bus1.do_idx, 32'd0);
    chk({tag, ".sof"}, bus1.do_sof, 32'd0);
    chk({tag, ".err"}, bus1.err_sof, 32'd0);
  endtask

  task automatic exp2(input string tag, input cmplx_t a, input cmplx_t b, input cmplx_t c,
                      input int k);
    chk({tag, ".vld"}, bus2.do_vld, 32'd1);
    chk({tag, ".o1re"}, bus2.out1_re, a.re);
    chk({tag, ".o1im"}, bus2.out1_im, a.im);
    chk({tag, ".o2re"}, bus2.out2_re, b.re);
    chk({tag, ".o2im"}, bus2.out2_im, b.im);
    chk({tag, ".o3re"}, bus2.out3_re, c.re);
    chk({tag, ".o3im"}, bus2.out3_im, c.im);
    chk({tag, ".idx"}, bus2.do_idx, k);
    chk({tag, ".sof"}, bus2.do_sof, (k == 0) ? 32'd1 : 32'd0);
    chk({tag, ".err"}, bus2.err_sof, 32'd0);
  endtask

  cmplx_t vec [6];
  cmplx_t cur [6];

  initial begin
    checks = 0;
    errors = 0;
    vec = '{'{13'h0FFF, 13'h1000}, '{13'h1000, 13'h0FFF}, '{13'h0001, 13'h1FFF},
            '{13'h1FFF, 13'h0000}, '{13'h0FFE, 13'h1001}, '{13'h1001, 13'h0FFE}};
    bus1.din_vld = 1'b0; bus1.din_sof = 1'b0; bus1.din_re = '0; bus1.din_im = '0;
    bus2.din_vld = 1'b0; bus2.din_sof = 1'b0; bus2.din_re = '0; bus2.din_im = '0;
    n_rst = 1'b1;
    @(posedge clk); @(posedge clk); #1;
    exp_zero("reset");
    n_rst = 1'b0;

    // Single contiguous frame.
    for (int n = 0; n < 27; n++) begin
      step(1'b1, n == 0, n, -n);
      if (n >= 18) exp_triple("frame1", n - 18, n - 9, n, n - 18);
      else         exp_none("frame1", 1'b0);
    end

    // Two back-to-back frames, second offset by 100.
    for (int f = 0; f < 2; f++) begin
      for (int n = 0; n < 27; n++) begin
        step(1'b1, n == 0, f * 100 + n, -(f * 100 + n));
        if (n >= 18) exp_triple("b2b", f * 100 + n - 18, f * 100 + n - 9, f * 100 + n, n - 18);
        else         exp_none("b2b", 1'b0);
      end
    end

    // Valid strobe toggled every cycle; outputs hold across idle cycles.
    for (int n = 0; n < 27; n++) begin
      step(1'b1, n == 0, n, -n);
      if (n >= 18) exp_triple("gap", n - 18, n - 9, n, n - 18);
      else         exp_none("gap", 1'b0);
      step(1'b0, 1'b0, 999, 999);
      exp_none("gap_idle", 1'b0);
      if (n >= 18) chk("gap_hold", bus1.out3_re, w(n));
    end

    // Start-of-frame reasserted at sample 14 aborts the partial frame.
    for (int n = 0; n < 41; n++) begin
      step(1'b1, (n == 0) || (n == 14), n, -n);
      if (n >= 32) exp_triple("abort", n - 18, n - 9, n, n - 32);
      else         exp_none("abort", n == 14);
    end

    // Reset mid-frame at sample 20, then non-sof samples are ignored.
    for (int n = 0; n < 20; n++) begin
      step(1'b1, n == 0, n, -n);
      if (n >= 18) exp_triple("prerst", n - 18, n - 9, n, n - 18);
      else         exp_none("prerst", 1'b0);
    end
    n_rst = 1'b1;
    step(1'b1, 1'b0, 20, -20);
    exp_zero("midrst");
    n_rst = 1'b0;
    for (int n = 0; n < 30; n++) begin
      step(1'b1, 1'b0, 300 + n, -(300 + n));
      exp_none("nosof", 1'b0);
    end
    for (int n = 0; n < 27; n++) begin
      step(1'b1, n == 0, 400 + n, -(400 + n));
      if (n >= 18) exp_triple("postrst", 382 + n, 391 + n, 400 + n, n - 18);
      else         exp_none("postrst", 1'b0);
    end
    step(1'b0, 1'b0, 0, 0);

    // SEG_LEN=2 instance: extreme values, second frame free-running without sof.
    for (int f = 0; f < 2; f++) begin
      for (int i = 0; i < 6; i++) cur[i] = (f == 0) ? vec[i] : ~vec[i];
      for (int n = 0; n < 6; n++) begin
        step2(1'b1, (f == 0) && (n == 0), cur[n]);
        if (n >= 4) begin
          exp2("seg2", cur[n - 4], cur[n - 2], cur[n], n - 4);
        end else begin
          chk("seg2.vld", bus2.do_vld, 32'd0);
          chk("seg2.err", bus2.err_sof, 32'd0);
        end
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/rd3_in_commutator.md
Name: rd3_in_commutator

Overview:
- Input stage directly upstream of the radix-3 butterfly.
- Takes one complex sample per valid cycle from a serial frame of N = 3*SEG_LEN samples.
- Buffers the first two thirds of the frame. During the last third it presents the triple x[k], x[k+N/3], x[k+2N/3] in parallel, with a valid strobe, as the butterfly's in1/in2/in3 inputs.
- Fully streaming: back-to-back frames are accepted with no stall.

Parameters:
- SIGN_BIT, 1, sign bits of a sample component.
- INT_BIT, 6, integer bits.
- FLT_BIT, 6, fraction bits; DW = SIGN_BIT+INT_BIT+FLT_BIT (13 by default).
- SEG_LEN, 9, samples per frame third (N/3); legal range 2 or more.
- IDX_W, 4, width of the index counter; must satisfy 2^IDX_W >= SEG_LEN.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- n_rst  in  1  reset, synchronous and active-high (1 = reset, sampled on the rising edge of clk).
- din_vld  in  1  din_re/din_im hold a valid sample this cycle.
- din_sof  in  1  start of frame; qualified by din_vld.
- din_re, din_im  in  DW each  two's-complement sample.
- out1_re, out1_im  out  DW each  x[k].
- out2_re, out2_im  out  DW each  x[k+SEG_LEN].
- out3_re, out3_im  out  DW each  x[k+2*SEG_LEN].
- do_vld  out  1  outputs valid; connects to the butterfly di_vld.
- do_idx  out  IDX_W  k of the presented triple.
- do_sof  out  1  high with the k=0 triple.
- err_sof  out  1  one-cycle pulse when a frame is aborted.

Behaviour:
- One clock, clk. Reset n_rst is synchronous and active-high.
- Reset values:
  - All outputs 0.
  - seg_cnt = 0, idx_cnt = 0, state = IDLE.
  - Buffer contents are don't-care; they are not reset.
- Counters:
  - idx_cnt runs 0..SEG_LEN-1. seg_cnt runs 0..2.
  - Both advance only on din_vld. Cycles with din_vld=0 hold all state, and do_vld is 0 on the following cycle.
- Sequence within a frame:
  - idx_cnt wraps to 0 and increments seg_cnt when it reaches SEG_LEN-1.
  - seg_cnt wraps 2 -> 0 at the last sample of a frame.
  - seg 0: the sample is written to bank A[idx_cnt].
  - seg 1: the sample is written to bank B[idx_cnt].
  - seg 2: no write. Output registers load out1 = A[idx_cnt], out2 = B[idx_cnt], out3 = din, do_idx = idx_cnt, do_sof = (idx_cnt == 0). do_vld is 1 on the next cycle.
- Latency: exactly 1 clk from an accepted seg-2 sample to its do_vld. Output registers hold their value when do_vld = 0.
- State machine (IDLE, RUN):
  - IDLE: samples without sof are ignored. din_vld & din_sof writes A[0], sets idx_cnt = 1, seg_cnt = 0, and moves to RUN.
  - RUN, din_vld & din_sof with (seg_cnt, idx_cnt) != (0, 0): the partial frame is aborted. err_sof pulses the next cycle, and the current sample is treated as sample 0 of a new frame (written to A[0], counters set to 0/1). No do_vld is produced for the aborted frame.
  - RUN, din_sof exactly at the expected position (0, 0): normal continuation, no error.
  - RUN, a frame starting without din_sof: accepted (free-running mode); do_sof still marks k=0.
- Abort during seg 2: the triples already emitted stand; the remaining ones are not emitted.
- n_rst asserted mid-frame: the next cycle is IDLE with all outputs 0. The partial frame is lost and there is no err_sof.
- Arithmetic: pure data movement; no scaling, rounding or sign extension. Outputs are bit-exact copies of the inputs.
- Storage: two register or RAM banks of SEG_LEN x 2*DW. Read of A/B and capture of din happen in the same cycle. A write to bank A at the start of the next frame never collides with a seg-2 read, because the seg-2 reads finish before the next seg 0 begins.

Decomposition:
- Shared package holds:
  - the DW derivation (SIGN_BIT+INT_BIT+FLT_BIT);
  - the state encoding IDLE=1'b0, RUN=1'b1;
  - seg_cnt encodings SEG0/1/2 (2 bits);
  - a cmplx sample typedef {re, im}.
- One sub-module is natural: rd3_seg_bank, a SEG_LEN-deep, 2*DW-wide single-write / single-read store with write enable. It is instantiated twice, for A and B.

Test Plan:
- Contiguous frame, SEG_LEN=9, din_sof on sample 0, din_re = n and din_im = -n for n = 0..26 -> 9 consecutive do_vld cycles starting 1 clk after sample 18.
  - Triple k has out1_re = k, out2_re = k+9, out3_re = k+18, and the negated values on im.
  - do_sof=1 only at k=0; do_idx = 0..8.
- Two back-to-back frames with no idle cycle, second frame offset by +100 -> 18 triples.
  - The second frame's k=0 triple is (100, 109, 118).
  - err_sof stays 0.
- din_vld toggled 1010... through a full frame -> identical triple values to scenario 1; each do_vld is isolated, 1 clk after its valid seg-2 input.
- din_sof reasserted at sample 14 (seg 1, idx 5) -> err_sof pulses once.
  - Counting restarts there: the first triple is (sample14, sample23, sample32).
  - No triples come from the aborted frame.
- n_rst held high for 1 clk at sample 20 (seg 2) -> the next cycle has all outputs 0 and do_vld 0.
  - Inputs without din_sof are ignored until the next sof.
  - err_sof stays 0.
- SEG_LEN=2 override, maximum values 0x0FFF / 0x1000 on re / im -> outputs are bit-exact; the idx wrap 1 -> 0 and seg wrap 2 -> 0 are correct.
